// File: rtl/bdiv16x8_seq_if.sv
// Request/response bundle for the 16/8 sequential divider: operands and start
// flow master->slave, status and results flow slave->master.
interface bdiv16x8_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, Q, R, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, Q, R, dz
  );
endinterface

// File: rtl/bdiv16x8_seq.sv
// Unsigned 16-bit by 8-bit restoring divider, one quotient bit per clock, MSB first.
// A zero divisor short-circuits to a flagged all-ones quotient one cycle after start.
module bdiv16x8_seq (
  input  logic          clk,
  input  logic          rst,
  bdiv16x8_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] dvd_r;
  logic [7:0]  dvs_r;
  logic [7:0]  rem_r;
  logic [15:0] quo_r;
  logic [4:0]  cnt_r;
  logic        zero_r;

  logic [15:0] q_r;
  logic [7:0]  r_r;
  logic        dz_r;

  logic        accept;
  logic        finish;
  logic [8:0]  shifted;
  logic [9:0]  diff;
  logic        fits;
  logic [7:0]  rem_nxt;

  assign accept = bus.start && (state != RUN);
  assign finish = zero_r || (cnt_r == 5'd16);

  // 9-bit partial remainder: previous remainder with the next dividend bit shifted in.
  assign shifted = {rem_r, dvd_r[15]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_r};
  // A successful trial always leaves a value below the divisor, so both top bits are clear.
  assign fits    = (diff[9:8] == 2'b00);
  assign rem_nxt = fits ? diff[7:0] : shifted[7:0];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (finish)    state_nxt = DONE;
      DONE: state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dvd_r  <= '0;
      dvs_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      cnt_r  <= '0;
      zero_r <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      dz_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dvd_r  <= bus.dividend;
        dvs_r  <= bus.divisor;
        rem_r  <= '0;
        quo_r  <= '0;
        cnt_r  <= '0;
        zero_r <= (bus.divisor == 8'h00);
      end else if (state == RUN) begin
        if (zero_r) begin
          q_r  <= '1;
          r_r  <= dvd_r[7:0];
          dz_r <= 1'b1;
        end else if (cnt_r == 5'd16) begin
          q_r  <= quo_r;
          r_r  <= rem_r;
          dz_r <= 1'b0;
        end else begin
          rem_r <= rem_nxt;
          quo_r <= {quo_r[14:0], fits};
          dvd_r <= {dvd_r[14:0], 1'b0};
          cnt_r <= cnt_r + 5'd1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.Q    = q_r;
  assign bus.R    = r_r;
  assign bus.dz   = dz_r;

endmodule

// File: tb/tb_bdiv16x8_seq.sv
// Self-checking bench for bdiv16x8_seq: directed vectors, divide-by-zero, reset
// behaviour, input isolation during RUN and a back-to-back round-trip stream.
module tb_bdiv16x8_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bdiv16x8_seq_if bus ();

  bdiv16x8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  localparam int unsigned N_RT = 3000;

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++;
    if (bus.dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", bus.dz); end
    total++;
    if (bus.Q !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h exp=0000", bus.Q); end
    total++;
    if (bus.R !== 8'h00) begin bad++; $display("FAIL reset_r got=%h exp=00", bus.R); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({bus.busy, bus.done, bus.dz, bus.Q, bus.R} !== 27'd0) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d got busy=%b done=%b dz=%b q=%h r=%h exp all zero",
                 i, bus.busy, bus.done, bus.dz, bus.Q, bus.R);
      end
    end
  endtask

  task automatic test_vectors();
    logic [15:0] vd[4] = '{16'hC350, 16'h03E8, 16'hFFFF, 16'hFFFF};
    logic [7:0]  vs[4] = '{8'hC8, 8'h07, 8'h01, 8'hFF};
    exp_t        ve[4] = '{'{16'h00FA, 8'h00, 1'b0}, '{16'h008E, 8'h06, 1'b0},
                           '{16'hFFFF, 8'h00, 1'b0}, '{16'h0101, 8'h00, 1'b0}};
    for (int v = 0; v < 4; v++) begin
      int c = 0;
      int nbusy = 0;
      int done_at = 0;
      exp_t e;
      exp_t got;
      @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = vd[v];
      bus.divisor = vs[v];
      sb.push_back(ve[v]);
      while (done_at == 0 && c < 40) begin
        @(negedge clk);
        c++;
        bus.start = 1'b0;
        if (bus.busy === 1'b1) nbusy++;
        if (bus.done === 1'b1) done_at = c;
      end
      total++;
      if (done_at != 18) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=18", v, done_at); end
      total++;
      if (nbusy != 17) begin bad++; $display("FAIL vec%0d_busy_cycles got=%0d exp=17", v, nbusy); end
      e = sb.pop_front();
      got = '{bus.Q, bus.R, bus.dz};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL vec%0d_result got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                 v, got.q, got.r, got.dz, e.q, e.r, e.dz);
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.Q !== e.q || bus.R !== e.r) begin
        bad++;
        $display("FAIL vec%0d_hold got done=%b q=%h r=%h exp done=0 q=%h r=%h",
                 v, bus.done, bus.Q, bus.R, e.q, e.r);
      end
    end
  endtask

  task automatic test_div_zero();
    int c = 0;
    int done_at = 0;
    int busy_late = 0;
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'h1234;
    bus.divisor = 8'h00;
    sb.push_back('{16'hFFFF, 8'h34, 1'b1});
    while (done_at == 0 && c < 40) begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
      if (c >= 2 && bus.busy === 1'b1) busy_late++;
      if (bus.done === 1'b1) done_at = c;
    end
    total++;
    if (done_at != 2) begin bad++; $display("FAIL dz_latency got=%0d exp=2", done_at); end
    e = sb.pop_front();
    got = '{bus.Q, bus.R, bus.dz};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL dz_result got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
               got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_late++;
    end
    total++;
    if (busy_late != 0) begin bad++; $display("FAIL dz_busy got=%0d busy cycles exp=0", busy_late); end
    total++;
    if (bus.dz !== 1'b1 || bus.Q !== 16'hFFFF) begin
      bad++;
      $display("FAIL dz_hold got dz=%b q=%h exp dz=1 q=ffff", bus.dz, bus.Q);
    end
  endtask

  task automatic test_reset_mid_run();
    int c = 0;
    int done_at = 0;
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'hC350;
    bus.divisor = 8'hC8;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      total++;
      if ({bus.busy, bus.done, bus.dz, bus.Q, bus.R} !== 27'd0) begin
        bad++;
        $display("FAIL abort_quiet cyc=%0d got busy=%b done=%b dz=%b q=%h r=%h exp all zero",
                 i, bus.busy, bus.done, bus.dz, bus.Q, bus.R);
      end
    end
    // start and reset on the same edge: the start must be dropped
    bus.start = 1'b1;
    bus.dividend = 16'h00FF;
    bus.divisor = 8'h03;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_wins_busy got=%b exp=0", bus.busy); end
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_at++;
    end
    total++;
    if (done_at != 0) begin bad++; $display("FAIL rst_wins_quiet got=%0d active cycles exp=0", done_at); end
    done_at = 0;
    bus.start = 1'b1;
    bus.dividend = 16'h7531;
    bus.divisor = 8'h0D;
    sb.push_back('{16'(16'h7531 / 16'h000D), 8'(16'h7531 % 16'h000D), 1'b0});
    while (done_at == 0 && c < 40) begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
      if (bus.done === 1'b1) done_at = c;
    end
    total++;
    if (done_at != 18) begin bad++; $display("FAIL post_abort_latency got=%0d exp=18", done_at); end
    e = sb.pop_front();
    got = '{bus.Q, bus.R, bus.dz};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL post_abort_result got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
               got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_ignore_inputs();
    int c = 0;
    int done_at = 0;
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'h2710;
    bus.divisor = 8'h37;
    sb.push_back('{16'(16'h2710 / 16'h0037), 8'(16'h2710 % 16'h0037), 1'b0});
    while (done_at == 0 && c < 40) begin
      @(negedge clk);
      c++;
      case (c)
        3:       begin bus.start = 1'b1; bus.dividend = 16'h1111; bus.divisor = 8'h05; end
        5:       begin bus.start = 1'b0; bus.dividend = 16'hFFFF; bus.divisor = 8'h00; end
        9:       bus.start = 1'b1;
        default: bus.start = 1'b0;
      endcase
      if (bus.done === 1'b1) done_at = c;
    end
    bus.start = 1'b0;
    total++;
    if (done_at != 18) begin bad++; $display("FAIL ignore_latency got=%0d exp=18", done_at); end
    e = sb.pop_front();
    got = '{bus.Q, bus.R, bus.dz};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL ignore_result got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
               got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int unsigned issued = 0;
    int unsigned checked = 0;
    int unsigned ok = 0;
    int idle = 0;
    logic [7:0] a;
    logic [7:0] b;
    exp_t e;
    exp_t got;
    @(negedge clk);
    a = 8'($urandom_range(255, 0));
    b = 8'($urandom_range(255, 1));
    bus.start = 1'b1;
    bus.dividend = 16'(a) * 16'(b);
    bus.divisor = b;
    sb.push_back('{16'(a), 8'h00, 1'b0});
    issued = 1;
    while (checked < N_RT && idle < 60) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        idle = 0;
        e = sb.pop_front();
        got = '{bus.Q, bus.R, bus.dz};
        checked++;
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL rt%0d got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                   checked, got.q, got.r, got.dz, e.q, e.r, e.dz);
        end else begin
          ok++;
        end
        if (issued < N_RT) begin
          a = 8'($urandom_range(255, 0));
          b = 8'($urandom_range(255, 1));
          bus.dividend = 16'(a) * 16'(b);
          bus.divisor = b;
          sb.push_back('{16'(a), 8'h00, 1'b0});
          issued++;
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        idle++;
      end
    end
    bus.start = 1'b0;
    total++;
    if (checked != N_RT) begin bad++; $display("FAIL rt_count got=%0d exp=%0d", checked, N_RT); end
    $display("round trip: %0d of %0d correct", ok, N_RT);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_div_zero();
    test_reset_mid_run();
    test_ignore_inputs();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
